// File: rtl/port_rx.sv
// rtl/port_rx.sv - receive end of a switch port: packet check, FIFO, counters, sticky errors
//
// Purpose: captures single-cycle switch packets, drops malformed, misdirected
// or overflowing ones, queues the rest in a DEPTH-entry FIFO and presents the
// head entry downstream on a valid/ready handshake.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   valid_i, source_i,    incoming packet (one-hot source, target bitmap,
//   target_i, data_i      payload byte)
//   ready_o               FIFO not full (advisory)
//   pkt_valid_o/ready_i   downstream handshake for the head entry
//   pkt_source_o/data_o/  head entry fields (binary source, payload,
//   pkt_mcast_o           multicast marker)
//   rx_count_o, drop_count_o  saturating packet counters
//   err_source_o, err_misdirect_o, err_overflow_o  sticky error flags
//   clr_i                 synchronous clear of counters and flags
module port_rx #(
  parameter int PORT_ID = 0,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [3:0]       source_i,
  input  logic [3:0]       target_i,
  input  logic [7:0]       data_i,
  output logic             ready_o,
  output logic             pkt_valid_o,
  input  logic             pkt_ready_i,
  output logic [1:0]       pkt_source_o,
  output logic [7:0]       pkt_data_o,
  output logic             pkt_mcast_o,
  output logic [CNT_W-1:0] rx_count_o,
  output logic [CNT_W-1:0] drop_count_o,
  output logic             err_source_o,
  output logic             err_misdirect_o,
  output logic             err_overflow_o,
  input  logic             clr_i
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Entry layout: [10:9] encoded source, [8:1] data, [0] multicast.
  logic [10:0]      mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             err_src_q, err_src_d;
  logic             err_mis_q, err_mis_d;
  logic             err_ovf_q, err_ovf_d;

  logic        full, empty, pop, push;
  logic        src_ok, tgt_hit, mcast;
  logic [1:0]  src_enc;
  logic [10:0] head;

  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign pop   = !empty && pkt_ready_i;

  // One-hot test: nonzero and clearing the lowest set bit leaves nothing.
  assign src_ok  = (source_i != 4'd0) && ((source_i & (source_i - 4'd1)) == 4'd0);
  assign tgt_hit = target_i[PORT_ID];
  assign mcast   = (target_i & (target_i - 4'd1)) != 4'd0;

  always_comb begin
    src_enc = 2'd0;
    unique case (source_i)
      4'b0010: src_enc = 2'd1;
      4'b0100: src_enc = 2'd2;
      4'b1000: src_enc = 2'd3;
      default: src_enc = 2'd0;
    endcase
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push = valid_i && src_ok && tgt_hit && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rx_cnt_d   = rx_cnt_q;
    drop_cnt_d = drop_cnt_q;
    err_src_d  = err_src_q;
    err_mis_d  = err_mis_q;
    err_ovf_d  = err_ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    if (valid_i) begin
      if (!src_ok)       err_src_d = 1'b1;
      else if (!tgt_hit) err_mis_d = 1'b1;
      else if (!push)    err_ovf_d = 1'b1;
      if (push) begin
        if (rx_cnt_q != {CNT_W{1'b1}}) rx_cnt_d = rx_cnt_q + CNT_ONE;
      end else begin
        if (drop_cnt_q != {CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + CNT_ONE;
      end
    end

    // Clear wins over this cycle's statistics but never touches the FIFO.
    if (clr_i) begin
      rx_cnt_d   = '0;
      drop_cnt_d = '0;
      err_src_d  = 1'b0;
      err_mis_d  = 1'b0;
      err_ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
      err_src_q  <= 1'b0;
      err_mis_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rx_cnt_q   <= rx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      err_src_q  <= err_src_d;
      err_mis_q  <= err_mis_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  // Storage needs no reset: outputs are gated while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {src_enc, data_i, mcast};
  end

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  assign ready_o         = !full;
  assign pkt_valid_o     = !empty;
  assign pkt_source_o    = empty ? 2'd0 : head[10:9];
  assign pkt_data_o      = empty ? 8'd0 : head[8:1];
  assign pkt_mcast_o     = empty ? 1'b0 : head[0];
  assign rx_count_o      = rx_cnt_q;
  assign drop_count_o    = drop_cnt_q;
  assign err_source_o    = err_src_q;
  assign err_misdirect_o = err_mis_q;
  assign err_overflow_o  = err_ovf_q;

endmodule

// File: tb/tb_port_rx.sv
// tb/tb_port_rx.sv - scoreboard testbench for port_rx
module tb_port_rx;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             valid_i = 1'b0;
  logic [3:0]       source_i = 4'd0;
  logic [3:0]       target_i = 4'd0;
  logic [7:0]       data_i = 8'd0;
  logic             ready_o;
  logic             pkt_valid_o;
  logic             pkt_ready_i = 1'b0;
  logic [1:0]       pkt_source_o;
  logic [7:0]       pkt_data_o;
  logic             pkt_mcast_o;
  logic [CNT_W-1:0] rx_count_o;
  logic [CNT_W-1:0] drop_count_o;
  logic             err_source_o;
  logic             err_misdirect_o;
  logic             err_overflow_o;
  logic             clr_i = 1'b0;

  port_rx #(.PORT_ID(0), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .source_i(source_i),
    .target_i(target_i), .data_i(data_i), .ready_o(ready_o),
    .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i),
    .pkt_source_o(pkt_source_o), .pkt_data_o(pkt_data_o),
    .pkt_mcast_o(pkt_mcast_o), .rx_count_o(rx_count_o),
    .drop_count_o(drop_count_o), .err_source_o(err_source_o),
    .err_misdirect_o(err_misdirect_o), .err_overflow_o(err_overflow_o),
    .clr_i(clr_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_e;
  int exp_rx = 0;
  int exp_drop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Monitor: compare head against scoreboard whenever valid; retire on pop.
  always @(negedge clk) begin
    if (reset && pkt_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pkt actual=%0h required=none", pkt_data_o);
      end else begin
        mon_e = exp_q[0];
        check("pkt_source", {30'd0, pkt_source_o}, {30'd0, mon_e[10:9]});
        check("pkt_data", {24'd0, pkt_data_o}, {24'd0, mon_e[8:1]});
        check("pkt_mcast", {31'd0, pkt_mcast_o}, {31'd0, mon_e[0]});
        if (pkt_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [3:0] s, input logic [3:0] t, input logic [7:0] d,
                      input bit acc, input logic [1:0] es, input bit em);
    valid_i  = 1'b1;
    source_i = s;
    target_i = t;
    data_i   = d;
    if (acc) begin
      exp_q.push_back({es, d, em});
      exp_rx = sat(exp_rx);
    end else begin
      exp_drop = sat(exp_drop);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    pkt_ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!pkt_valid_o) break;
      @(posedge clk);
      #1;
    end
    pkt_ready_i = 1'b0;
    check("drain_done", {31'd0, pkt_valid_o}, 32'd0);
    check("sb_empty", exp_q.size(), 32'd0);
  endtask

  task automatic clear();
    clr_i = 1'b1;
    @(posedge clk);
    #1;
    clr_i = 1'b0;
    exp_rx = 0;
    exp_drop = 0;
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_rx"}, {28'd0, rx_count_o}, exp_rx);
    check({tag, "_drop"}, {28'd0, drop_count_o}, exp_drop);
  endtask

  initial begin
    #2;
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    check("rst_valid", {31'd0, pkt_valid_o}, 32'd0);
    check("rst_src", {30'd0, pkt_source_o}, 32'd0);
    check("rst_data", {24'd0, pkt_data_o}, 32'd0);
    check("rst_mcast", {31'd0, pkt_mcast_o}, 32'd0);
    check("rst_errs", {29'd0, err_source_o, err_misdirect_o, err_overflow_o}, 32'd0);
    check_cnt("rst");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Basic single packet, one-cycle latency.
    send(4'b0010, 4'b0001, 8'hA5, 1'b1, 2'd1, 1'b0);
    check("lat_valid", {31'd0, pkt_valid_o}, 32'd1);
    check("lat_data", {24'd0, pkt_data_o}, 32'hA5);
    check("lat_src", {30'd0, pkt_source_o}, 32'd1);
    check_cnt("first");
    drain();

    // Fill to full, overflow the ninth, drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      send(4'b0001 << (i % 4), (i % 2) ? 4'b0011 : 4'b0001, 8'h10 + 8'(i),
           1'b1, 2'(i % 4), (i % 2) == 1);
      if (i == DEPTH - 2) check("ready_before_full", {31'd0, ready_o}, 32'd1);
      if (i == DEPTH - 1) check("ready_full", {31'd0, ready_o}, 32'd0);
    end
    send(4'b0001, 4'b0001, 8'hEE, 1'b0, 2'd0, 1'b0);
    check("ovf_flag", {31'd0, err_overflow_o}, 32'd1);
    check("ovf_src_flag", {31'd0, err_source_o}, 32'd0);
    check_cnt("ovf");
    drain();
    check("ready_after_drain", {31'd0, ready_o}, 32'd1);

    // Full FIFO with simultaneous pop and push: accepted, stays full.
    clear();
    check("clr_ovf", {31'd0, err_overflow_o}, 32'd0);
    for (int i = 0; i < DEPTH; i++)
      send(4'b1000, 4'b0101, 8'h40 + 8'(i), 1'b1, 2'd3, 1'b1);
    pkt_ready_i = 1'b1;
    send(4'b0100, 4'b0001, 8'h5A, 1'b1, 2'd2, 1'b0);
    pkt_ready_i = 1'b0;
    check("pushpop_full", {31'd0, ready_o}, 32'd0);
    check("pushpop_noovf", {31'd0, err_overflow_o}, 32'd0);
    check_cnt("pushpop");
    drain();

    // Malformed packets.
    send(4'b0000, 4'b0001, 8'h01, 1'b0, 2'd0, 1'b0);
    check("err_src", {31'd0, err_source_o}, 32'd1);
    send(4'b0001, 4'b0100, 8'h02, 1'b0, 2'd0, 1'b0);
    check("err_mis", {31'd0, err_misdirect_o}, 32'd1);
    check("mal_noovf", {31'd0, err_overflow_o}, 32'd0);
    check_cnt("malformed");
    check("mal_empty", {31'd0, pkt_valid_o}, 32'd0);

    // Back-to-back stream saturating the receive counter.
    clear();
    pkt_ready_i = 1'b1;
    for (int i = 0; i < 20; i++)
      send(4'b0001, 4'b0001, 8'(i), 1'b1, 2'd0, 1'b0);
    pkt_ready_i = 1'b0;
    check("rx_sat", {28'd0, rx_count_o}, 32'd15);
    check("stream_ready", {31'd0, ready_o}, 32'd1);
    clr_i = 1'b1;
    send(4'b0100, 4'b1101, 8'h3C, 1'b1, 2'd2, 1'b1);
    clr_i = 1'b0;
    exp_rx = 0;
    exp_drop = 0;
    check_cnt("clr_same");
    drain();

    // Reset with entries queued flushes at once.
    for (int i = 0; i < 5; i++)
      send(4'b0010, 4'b0001, 8'h60 + 8'(i), 1'b1, 2'd1, 1'b0);
    check_cnt("pre_rst");
    #1;
    reset = 1'b0;
    exp_q.delete();
    exp_rx = 0;
    exp_drop = 0;
    #1;
    check("mid_rst_valid", {31'd0, pkt_valid_o}, 32'd0);
    check("mid_rst_ready", {31'd0, ready_o}, 32'd1);
    check_cnt("mid_rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    send(4'b1000, 4'b0001, 8'h77, 1'b1, 2'd3, 1'b0);
    check("post_rst_data", {24'd0, pkt_data_o}, 32'h77);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
